hazard_bypass_unit: RTL

- Read-side companion of the pipeline register file.
- Tracks destination tags of in-flight instructions (EX, MEM, WB) and selects each decode-stage operand from the register-file read ports or a bypass source.
- Raises a one-cycle load-use stall and drives the register file's write number and write enable from its WB tag.
- Sits between ID and EX; `qa`/`qb` come from the register file, and `rf_wn`/`rf_we` go back to it.

---
 rtl/hazard_bypass_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_bypass_unit.sv
// Decode-stage hazard unit: tracks EX/MEM/WB destination tags, selects bypass sources
// for both operands, raises the load-use stall and drives the register-file write port.
module hazard_bypass_unit #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_wn,
    input  logic          id_we,
    input  logic          id_m2reg,
    input  logic          flush,
    input  logic [DW-1:0] qa,
    input  logic [DW-1:0] qb,
    input  logic [DW-1:0] ex_res,
    input  logic [DW-1:0] mem_res,
    input  logic [DW-1:0] mem_mdata,
    input  logic [DW-1:0] wb_d,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          stall,
    output logic [AW-1:0] rf_wn,
    output logic          rf_we,
    output logic [CW-1:0] stall_cnt
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wn;
        logic          m2reg;
    } tag_t;

    localparam tag_t BUBBLE = '0;

    tag_t          ex_tag_q, ex_tag_d;
    tag_t          mem_tag_q, mem_tag_d;
    tag_t          wb_tag_q, wb_tag_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_int;

    function automatic logic tag_hit(input tag_t t, input logic [AW-1:0] r);
        return t.we && (t.wn == r) && (r != '0);
    endfunction

    // Youngest producer wins; WB is still needed because the RF write lands at the edge.
    function automatic logic [1:0] fwd_sel(input tag_t ex, input tag_t mem, input tag_t wb,
                                           input logic [AW-1:0] r);
        if (tag_hit(ex, r))       return 2'b01;
        else if (tag_hit(mem, r)) return 2'b10;
        else if (tag_hit(wb, r))  return 2'b11;
        else                      return 2'b00;
    endfunction

    always_comb begin
        fwda = fwd_sel(ex_tag_q, mem_tag_q, wb_tag_q, id_rs);
        fwdb = fwd_sel(ex_tag_q, mem_tag_q, wb_tag_q, id_rt);

        case (fwda)
            2'b01:   opa = ex_res;
            2'b10:   opa = mem_tag_q.m2reg ? mem_mdata : mem_res;
            2'b11:   opa = wb_d;
            default: opa = qa;
        endcase

        case (fwdb)
            2'b01:   opb = ex_res;
            2'b10:   opb = mem_tag_q.m2reg ? mem_mdata : mem_res;
            2'b11:   opb = wb_d;
            default: opb = qb;
        endcase
    end

    always_comb begin
        stall_int = id_valid && !flush && ex_tag_q.we && ex_tag_q.m2reg &&
                    (ex_tag_q.wn != '0) &&
                    ((id_use_rs && (id_rs == ex_tag_q.wn)) ||
                     (id_use_rt && (id_rt == ex_tag_q.wn)));
    end

    // Tags always advance; a stall or flush simply injects a bubble into EX.
    always_comb begin
        wb_tag_d  = mem_tag_q;
        mem_tag_d = ex_tag_q;
        ex_tag_d  = BUBBLE;
        if (id_valid && !stall_int && !flush) begin
            ex_tag_d.we    = id_we;
            ex_tag_d.wn    = id_wn;
            ex_tag_d.m2reg = id_m2reg;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_int && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag_q    <= BUBBLE;
            mem_tag_q   <= BUBBLE;
            wb_tag_q    <= BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= mem_tag_d;
            wb_tag_q    <= wb_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_int;
    assign rf_we     = wb_tag_q.we && (wb_tag_q.wn != '0);
    assign rf_wn     = wb_tag_q.wn;
    assign stall_cnt = stall_cnt_q;

endmodule
